// File: rtl/hiscore_upload.sv
// Serves hps_io upload reads of the hiscore/NVRAM RAM, one byte per strobe,
// and appends a two's-complement checksum byte after the payload.
//
// state | meaning
// IDLE  | waiting for an ioctl_rd strobe
// REQ   | holding ram_req until the core arbiter grants the RAM port
// READ  | ram_rd issued, counting RAM_LAT cycles before sampling ram_q
// FIX   | returning the checksum byte (addr==SIZE) or 0xFF (addr>SIZE)
module hiscore_upload #(
    parameter int AW      = 10,
    parameter int SIZE    = 1024,
    parameter int RAM_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [15:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          ram_req,
    input  logic          ram_gnt,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, REQ, READ, FIX} state_t;

    localparam logic [16:0] SIZE_W   = 17'(SIZE);
    localparam logic [1:0]  LAT_LOAD = 2'(RAM_LAT - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      din_q, din_d;
    logic [7:0]      sum_q, sum_d;
    logic [1:0]      lat_q, lat_d;
    logic            wait_q, wait_d;
    logic            req_q, req_d;
    logic            err_q, err_d;
    logic            upload_q, upload_d;
    logic            fix_sum_q, fix_sum_d;
    logic            in_range;
    logic            upload_rise;

    assign in_range    = {1'b0, ioctl_addr} < SIZE_W;
    assign upload_rise = ioctl_upload & ~upload_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        din_d     = din_q;
        sum_d     = sum_q;
        lat_d     = lat_q;
        wait_d    = wait_q;
        req_d     = req_q;
        err_d     = err_q;
        fix_sum_d = fix_sum_q;
        upload_d  = ioctl_upload;

        case (state_q)
            IDLE: begin
                if (ioctl_rd && ioctl_upload) begin
                    wait_d = 1'b1;
                    if (in_range) begin
                        addr_d  = ioctl_addr[AW-1:0];
                        req_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        fix_sum_d = ({1'b0, ioctl_addr} == SIZE_W);
                        state_d   = FIX;
                    end
                end
            end
            REQ: begin
                if (!ioctl_upload) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    wait_d  = 1'b0;
                end else if (ram_gnt) begin
                    lat_d   = LAT_LOAD;
                    state_d = READ;
                end
            end
            READ: begin
                // An aborted session leaves din/sum untouched; the in-flight ram_q is dropped.
                if (!ioctl_upload) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    wait_d  = 1'b0;
                end else if (lat_q == 2'd0) begin
                    din_d   = ram_q;
                    sum_d   = sum_q + ram_q;
                    req_d   = 1'b0;
                    wait_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            FIX: begin
                if (ioctl_upload) begin
                    din_d = fix_sum_q ? (8'h00 - sum_q) : 8'hFF;
                end
                wait_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && ioctl_rd) begin
            err_d = 1'b1;
        end

        if (upload_rise) begin
            sum_d = 8'h00;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            din_q     <= 8'h00;
            sum_q     <= 8'h00;
            lat_q     <= 2'd0;
            wait_q    <= 1'b0;
            req_q     <= 1'b0;
            err_q     <= 1'b0;
            upload_q  <= 1'b0;
            fix_sum_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            sum_q     <= sum_d;
            lat_q     <= lat_d;
            wait_q    <= wait_d;
            req_q     <= req_d;
            err_q     <= err_d;
            upload_q  <= upload_d;
            fix_sum_q <= fix_sum_d;
        end
    end

    // Strobe follows the grant in the same cycle so a granted port is never held idle.
    assign ram_rd     = (state_q == REQ) & ram_gnt & ioctl_upload;
    assign ram_addr   = addr_q;
    assign ram_req    = req_q;
    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign err        = err_q;

endmodule

// File: tb/tb_hiscore_upload.sv
// Directed bench for hiscore_upload: expected bytes go into a scoreboard queue,
// a monitor pops one each time ioctl_wait falls and compares ioctl_din.
module tb_hiscore_upload;

    localparam int AW = 10;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          ioctl_upload;
    logic          ioctl_rd;
    logic [15:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          ram_req;
    logic          ram_gnt;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_q = 8'h00;
    logic          err;

    logic [7:0] mem [0:1023];
    logic [7:0] exp_q [$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic       wait_prev = 1'b0;

    hiscore_upload #(.AW(AW), .SIZE(3), .RAM_LAT(1)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .ram_req      (ram_req),
        .ram_gnt      (ram_gnt),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_q        (ram_q),
        .err          (err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_rd) ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed (or aborted) read ends with a falling ioctl_wait.
    always @(negedge clk_sys) begin
        if (wait_prev && !ioctl_wait) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: din %h with no expected entry at %0t", ioctl_din, $time);
            end else begin
                chk("sb_din", 16'(ioctl_din), 16'(exp_q.pop_front()));
            end
        end
        wait_prev = ioctl_wait;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [15:0] a);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
    endtask

    // In-range read with the grant already high: ram_rd in cycle 1, byte in cycle 3.
    task automatic read_ram(input logic [15:0] a, input logic [7:0] exp);
        exp_q.push_back(exp);
        strobe(a);
        chk("c1_ram_rd", 16'(ram_rd), 16'd1);
        chk("c1_wait", 16'(ioctl_wait), 16'd1);
        chk("c1_ram_addr", 16'(ram_addr), 16'(a[AW-1:0]));
        tick();
        chk("c2_ram_rd", 16'(ram_rd), 16'd0);
        chk("c2_wait_req", 16'({ioctl_wait, ram_req}), 16'b11);
        tick();
        chk("c3_wait_req", 16'({ioctl_wait, ram_req}), 16'b00);
        chk("c3_din", 16'(ioctl_din), 16'(exp));
    endtask

    task automatic read_fix(input logic [15:0] a, input logic [7:0] exp);
        exp_q.push_back(exp);
        strobe(a);
        chk("fix_c1_wait", 16'(ioctl_wait), 16'd1);
        chk("fix_c1_req", 16'(ram_req), 16'd0);
        tick();
        chk("fix_c2_wait", 16'(ioctl_wait), 16'd0);
        chk("fix_c2_din", 16'(ioctl_din), 16'(exp));
        chk("fix_c2_req", 16'(ram_req), 16'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 16'h0000;
        ram_gnt      = 1'b1;
        repeat (3) tick();
        chk("rst_outputs", 16'({ioctl_din, ioctl_wait, ram_req, ram_rd, err}), 16'h0);
        chk("rst_ram_addr", 16'(ram_addr), 16'h0);
        reset_n = 1'b1;
        tick();
        ioctl_upload = 1'b1;
        tick();

        // 1: payload then checksum -(0x11+0x22+0x33) = 0x9A
        read_ram(16'd0, 8'h11);
        read_ram(16'd1, 8'h22);
        read_ram(16'd2, 8'h33);
        read_fix(16'd3, 8'h9A);

        // 2: grant withheld for 20 cycles
        ram_gnt = 1'b0;
        exp_q.push_back(8'h22);
        strobe(16'd1);
        for (int i = 0; i < 20; i++) begin
            chk("t2_hold", 16'({ram_req, ioctl_wait, ram_rd}), 16'b110);
            tick();
        end
        ram_gnt = 1'b1;
        #1;
        chk("t2_rd_on_gnt", 16'(ram_rd), 16'd1);
        tick();
        chk("t2_rd_single", 16'(ram_rd), 16'd0);
        chk("t2_wait", 16'(ioctl_wait), 16'd1);
        tick();
        chk("t2_done", 16'({ioctl_wait, ram_req}), 16'b00);
        chk("t2_din", 16'(ioctl_din), 16'h22);

        // 3: overlapping strobe sets sticky err, second request dropped
        chk("t3_err_pre", 16'(err), 16'd0);
        exp_q.push_back(8'h33);
        ioctl_addr = 16'd2;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_addr = 16'd0;
        tick();
        ioctl_rd = 1'b0;
        chk("t3_err_set", 16'(err), 16'd1);
        tick();
        chk("t3_din", 16'(ioctl_din), 16'h33);
        repeat (4) tick();
        chk("t3_idle", 16'({ram_req, ioctl_wait}), 16'b00);
        chk("t3_err_sticky", 16'(err), 16'd1);
        ioctl_upload = 1'b0;
        tick();
        ioctl_upload = 1'b1;
        tick();
        chk("t3_err_clr", 16'(err), 16'd0);
        read_fix(16'd3, 8'h00);

        // 4: beyond the checksum byte
        read_fix(16'h0400, 8'hFF);

        // 5: session dropped while in READ
        exp_q.push_back(8'hFF);
        strobe(16'd0);
        chk("t5_rd", 16'(ram_rd), 16'd1);
        tick();
        ioctl_upload = 1'b0;
        tick();
        chk("t5_abort", 16'({ram_req, ioctl_wait}), 16'b00);
        chk("t5_din_keep", 16'(ioctl_din), 16'hFF);
        repeat (3) tick();
        chk("t5_late_q", 16'(ioctl_din), 16'hFF);

        // 6: asynchronous reset mid-REQ
        ioctl_upload = 1'b1;
        ram_gnt      = 1'b0;
        tick();
        exp_q.push_back(8'h00);
        strobe(16'd1);
        tick();
        chk("t6_in_req", 16'({ram_req, ioctl_wait}), 16'b11);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_outputs", 16'({ioctl_din, ioctl_wait, ram_req, ram_rd, err}), 16'h0);
        chk("t6_rst_addr", 16'(ram_addr), 16'h0);
        tick();
        reset_n = 1'b1;
        ram_gnt = 1'b1;
        tick();
        tick();
        chk("t6_idle", 16'({ram_req, ioctl_wait, ram_rd}), 16'b000);
        read_ram(16'd2, 8'h33);

        repeat (3) tick();
        chk("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
